// File: rtl/reg_vga_ctrl.sv
// reg_vga_ctrl: VGA register block on the local peripheral bus.
//
// Provides enable and interrupt-enable control, live and sticky (W1C) blanking status with a
// level interrupt, a free-running frame counter and NUM_PLANE double-buffered scroll registers
// whose active copies load at vertical-blank start.
//
// Optional build macro: VGA_LINE_COUNTER_EN adds a saturating read-only line counter at 0x0C.
// Without it, 0x0C is unmapped and no counter logic exists.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   sel_i        block select
//   addr_i       byte address, only [7:2] decoded
//   we_i         [2]=write, [1:0]: 00 byte, 01 halfword, 10 word
//   wdata_i      write data
//   rdata_o      combinational read data (0 when unselected or unmapped)
//   vblank_i     vertical blank from the timing generator
//   hblank_i     horizontal blank from the timing generator
//   vga_en_o     VGA enable (CTRL bit 0)
//   irq_o        level interrupt request
//   scroll_x_o   active X offsets, plane p at [p*SCROLL_W +: SCROLL_W]
//   scroll_y_o   active Y offsets, same packing
module reg_vga_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_PLANE = 2,
    parameter int unsigned SCROLL_W  = 10,
    parameter int unsigned FCNT_W    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          sel_i,
    input  logic [XLEN-1:0]               addr_i,
    input  logic [2:0]                    we_i,
    input  logic [XLEN-1:0]               wdata_i,
    output logic [XLEN-1:0]               rdata_o,
    input  logic                          vblank_i,
    input  logic                          hblank_i,
    output logic                          vga_en_o,
    output logic                          irq_o,
    output logic [NUM_PLANE*SCROLL_W-1:0] scroll_x_o,
    output logic [NUM_PLANE*SCROLL_W-1:0] scroll_y_o
);

    localparam logic [5:0]  IdxCtrl   = 6'h00;
    localparam logic [5:0]  IdxStat   = 6'h01;
    localparam logic [5:0]  IdxFcnt   = 6'h02;
`ifdef VGA_LINE_COUNTER_EN
    localparam logic [5:0]  IdxLine   = 6'h03;
`endif
    localparam int unsigned IdxScroll = 8;

    logic [5:0]      word_idx;
    logic            wr_en;
    logic [XLEN-1:0] wmask;

    assign word_idx = addr_i[7:2];
    assign wr_en    = sel_i & we_i[2];

    // Byte-lane mask of the bits a write may touch.
    always_comb begin
        wmask = '0;
        case (we_i[1:0])
            2'b00:   wmask[7:0]  = '1;
            2'b01:   wmask[15:0] = '1;
            default: wmask       = '1;
        endcase
    end

    logic unused_bus;
    assign unused_bus = ^{addr_i[XLEN-1:8], addr_i[1:0], wdata_i, wmask};

    // ------------------------------------------------------------------
    // Blank edge detection
    // ------------------------------------------------------------------
    logic vblank_q, hblank_q;
    logic vrise, hrise;

    assign vrise = vblank_i & ~vblank_q;
    assign hrise = hblank_i & ~hblank_q;

    // ------------------------------------------------------------------
    // CTRL, STAT flags, FCNT
    // ------------------------------------------------------------------
    logic [2:0]        ctrl_q, ctrl_d;
    logic              vflag_q, vflag_d;
    logic              hflag_q, hflag_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && word_idx == IdxCtrl) begin
            // CTRL bits sit in byte 0, which every lane size covers.
            ctrl_d = wdata_i[2:0];
        end

        vflag_d = vflag_q;
        hflag_d = hflag_q;
        if (wr_en && word_idx == IdxStat) begin
            if (wmask[8] && wdata_i[8]) vflag_d = 1'b0;
            if (wmask[9] && wdata_i[9]) hflag_d = 1'b0;
        end
        // Applied after the clear so a coincident event wins.
        if (vrise && ctrl_q[0]) vflag_d = 1'b1;
        if (hrise && ctrl_q[0]) hflag_d = 1'b1;

        fcnt_d = fcnt_q;
        if (wr_en && word_idx == IdxFcnt) begin
            fcnt_d = '0;
        end else if (vrise && ctrl_q[0]) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vblank_q <= 1'b0;
            hblank_q <= 1'b0;
            ctrl_q   <= '0;
            vflag_q  <= 1'b0;
            hflag_q  <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            vblank_q <= vblank_i;
            hblank_q <= hblank_i;
            ctrl_q   <= ctrl_d;
            vflag_q  <= vflag_d;
            hflag_q  <= hflag_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign vga_en_o = ctrl_q[0];
    assign irq_o    = (vflag_q & ctrl_q[1]) | (hflag_q & ctrl_q[2]);

`ifdef VGA_LINE_COUNTER_EN
    // ------------------------------------------------------------------
    // Line counter: vrise restart dominates a coincident hrise
    // ------------------------------------------------------------------
    logic [11:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (vrise) begin
            line_d = '0;
        end else if (hrise && ctrl_q[0] && !(&line_q)) begin
            line_d = line_q + 12'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Scroll planes: staging written by the bus, active loaded from staging
    // ------------------------------------------------------------------
    logic [NUM_PLANE-1:0][XLEN-1:0] stg_word;
    logic                           load_active;

    // Disabled: active tracks staging every cycle. Enabled: only at vblank start.
    assign load_active = ~ctrl_q[0] | vrise;

    for (genvar p = 0; p < NUM_PLANE; p++) begin : g_plane
        logic [SCROLL_W-1:0] stg_x_q, stg_x_d;
        logic [SCROLL_W-1:0] stg_y_q, stg_y_d;
        logic [SCROLL_W-1:0] act_x_q, act_y_q;
        logic                hit;

        assign hit = wr_en && (word_idx == 6'(IdxScroll + p));

        always_comb begin
            stg_x_d = stg_x_q;
            stg_y_d = stg_y_q;
            if (hit) begin
                stg_x_d = (stg_x_q & ~wmask[SCROLL_W-1:0])
                        | (wdata_i[SCROLL_W-1:0] & wmask[SCROLL_W-1:0]);
                stg_y_d = (stg_y_q & ~wmask[16 +: SCROLL_W])
                        | (wdata_i[16 +: SCROLL_W] & wmask[16 +: SCROLL_W]);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stg_x_q <= '0;
                stg_y_q <= '0;
                act_x_q <= '0;
                act_y_q <= '0;
            end else begin
                stg_x_q <= stg_x_d;
                stg_y_q <= stg_y_d;
                // Loads the pre-write staging value; a same-cycle write waits for the next load.
                if (load_active) begin
                    act_x_q <= stg_x_q;
                    act_y_q <= stg_y_q;
                end
            end
        end

        assign stg_word[p] = (XLEN'(stg_y_q) << 16) | XLEN'(stg_x_q);
        assign scroll_x_o[p*SCROLL_W +: SCROLL_W] = act_x_q;
        assign scroll_y_o[p*SCROLL_W +: SCROLL_W] = act_y_q;
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            case (word_idx)
                IdxCtrl: rdata_o[2:0] = ctrl_q;
                IdxStat: begin
                    rdata_o[0] = vblank_i;
                    rdata_o[1] = hblank_i;
                    rdata_o[8] = vflag_q;
                    rdata_o[9] = hflag_q;
                end
                IdxFcnt: rdata_o[FCNT_W-1:0] = fcnt_q;
`ifdef VGA_LINE_COUNTER_EN
                IdxLine: rdata_o[11:0] = line_q;
`endif
                default: begin
                    for (int p = 0; p < NUM_PLANE; p++) begin
                        if (word_idx == 6'(IdxScroll + p)) rdata_o = stg_word[p];
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/reg_vga_ctrl.md
Name: reg_vga_ctrl

Overview:
Second-generation VGA register block on the local peripheral bus, sitting between the bus decoder and the VGA timing/pixel pipeline. It provides:
- Enable and interrupt-enable control.
- Live and sticky (write-1-to-clear) blanking status, with an interrupt output.
- A free-running frame counter.
- NUM_PLANE per-plane scroll registers, double-buffered so they update only at vertical-blank start.

Parameters:
XLEN, 32, bus data width (rdata/wdata)
NUM_PLANE, 2, number of scroll planes (1..8)
SCROLL_W, 10, width of each X and Y scroll offset (1..16)
FCNT_W, 16, frame counter width (1..XLEN)

Ports:
clk  input  1  global clock
rst  input  1  synchronous active-high reset
sel  input  1  block select
addr  input  XLEN  byte address; only addr[7:2] decoded
we  input  3  we[2]=write; we[1:0]: 2'b10 word, 2'b01 halfword, 2'b00 byte
wdata  input  XLEN  write data
rdata  output  XLEN  read data
vblank  input  1  vertical blank from timing generator (clk domain)
hblank  input  1  horizontal blank from timing generator (clk domain)
vga_en  output  1  VGA module enable
irq  output  1  level interrupt request
scroll_x  output  NUM_PLANE*SCROLL_W  active X offsets, plane p at [p*SCROLL_W +: SCROLL_W]
scroll_y  output  NUM_PLANE*SCROLL_W  active Y offsets, same packing

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it clears every register, so all outputs and all register fields read 0.
- Write lanes: a write with we[2]=1 updates bits [7:0] (byte), [15:0] (halfword) or [XLEN-1:0] (word) of the addressed register. addr[1:0] is ignored. Bits outside a register's defined fields are read-only 0.
- Read path: rdata is combinational. It is 0 when sel=0 or the address is unmapped. Reads have no side effects.
- Edge detect: vblank_d and hblank_d register the inputs each cycle. vrise = vblank & ~vblank_d; hrise = hblank & ~hblank_d.
- 0x00 CTRL (RW):
  - bit0 vga_en, driven directly to the output.
  - bit1 vie (vblank interrupt enable).
  - bit2 hie (hblank interrupt enable).
- 0x04 STAT:
  - bit0 = vblank (live), bit1 = hblank (live).
  - bit8 vflag: set on vrise while vga_en=1.
  - bit9 hflag: set on hrise while vga_en=1.
  - vflag/hflag are cleared by writing 1 to the bit (W1C). If a set event and a clear write occur in the same cycle, the set wins.
- irq = (vflag & vie) | (hflag & hie), from registered state. irq rises the cycle after the first clk edge that samples vblank=1.
- 0x08 FCNT:
  - Read-only counter in [FCNT_W-1:0]. Increments on vrise while vga_en=1.
  - Wraps from all-ones to 0.
  - Any write clears it to 0; a clear coinciding with an increment leaves 0.
- 0x20+4*p SCROLLp, for p < NUM_PLANE (RW staging):
  - X in [SCROLL_W-1:0], Y in [16+SCROLL_W-1:16]. A byte or halfword write only touches X bits inside the lane.
  - Staging reads back the staging value, not the active value.
  - Active update on vrise: the active registers (scroll_x/scroll_y) load staging values as they stood before any same-cycle write. A write in that cycle lands in staging and applies at the next vrise.
  - While vga_en=0, active follows staging every cycle (one-cycle latency after the write).
- Addresses 0x20+4*p with p ≥ NUM_PLANE are unmapped.
- vga_en 1→0 clears neither the flags nor FCNT.

Optional Feature:
VGA_LINE_COUNTER_EN
- Defined: adds register 0x0C LINE (read-only, [11:0]).
  - Increments on hrise while vga_en=1.
  - Resets to 0 on vrise; if vrise and hrise coincide, the result is 0.
  - Saturates at 12'hFFF. Writes are ignored.
- Not defined: 0x0C is unmapped, reads 0, and no counter logic is synthesised.

Test Plan:
1. Reset: assert rst 2 cycles → vga_en=0, irq=0, scroll_x/scroll_y=0, and reads of 0x00/0x04/0x08/0x20 all return 0.
2. Interrupt path:
   - Write 0x00=0x3, pulse vblank high for 10 cycles.
   - STAT reads 0x101 during the pulse; irq=1 one cycle after vblank is first sampled high.
   - Write 0x04=0x100 → irq=0, STAT reads 0x000.
   - A W1C in the same cycle as a new vrise leaves vflag=1.
3. Frame counter:
   - vga_en=1, 5 vblank pulses → FCNT=5; write 0x08 → 0.
   - With FCNT_W=4, 17 pulses → 1 (wrap).
   - With vga_en=0, pulses leave FCNT unchanged.
4. Scroll shadowing:
   - vga_en=1, word write 0x20=0x0050_0123 → scroll_x[0]=0, unchanged until vrise, then 0x123 and scroll_y[0]=0x050.
   - A write 0x20=0x0000_0001 in the vrise cycle → active stays 0x123 until the next vrise.
   - With vga_en=0, the active value updates one cycle after the write.
5. Lanes/decode:
   - Byte write 0x22=0x0000_01FF → only X[7:0]=0xFF.
   - Read of 0x20+4*NUM_PLANE returns 0.
   - sel=0 write to 0x00 has no effect.
6. VGA_LINE_COUNTER_EN defined, vga_en=1: 480 hblank pulses → LINE=480; a vblank pulse → 0. Without the macro, 0x0C reads 0.
